// File: rtl/tick_pixel_sequencer.sv
// Tick-paced raster walker: emits one test-pattern pixel per divider tick over a valid/ready
// stream, queueing ticks under backpressure and idling a tick-counted gap between frames.
module tick_pixel_sequencer #(
   parameter int unsigned H_PIX     = 16,
   parameter int unsigned V_PIX     = 12,
   parameter int unsigned GAP_TICKS = 2,
   parameter int unsigned TICK_Q_W  = 3,
   parameter int unsigned CB_BIT    = 2
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     tick_i,
   input  logic                     enable_i,
   input  logic [1:0]               pattern_sel_i,
   input  logic                     out_ready_i,
   output logic                     pix_valid_o,
   output logic [$clog2(H_PIX)-1:0] pix_x_o,
   output logic [$clog2(V_PIX)-1:0] pix_y_o,
   output logic [7:0]               pix_data_o,
   output logic                     frame_start_o,
   output logic                     frame_done_o,
   output logic                     overrun_o
);

   localparam int unsigned XW = $clog2(H_PIX);
   localparam int unsigned YW = $clog2(V_PIX);
   localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   localparam logic [XW-1:0]       XLast   = XW'(H_PIX - 1);
   localparam logic [YW-1:0]       YLast   = YW'(V_PIX - 1);
   localparam logic [GW-1:0]       GapLast = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [TICK_Q_W-1:0] PendMax = '1;
   localparam logic                GapEn   = (GAP_TICKS > 0);

   typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

   state_e              state_q;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [TICK_Q_W-1:0] pend_q, pend_d;
   logic [GW-1:0]       gap_q;
   logic [1:0]          pat_q, pat_d;
   logic [7:0]          data_q, data_d;
   logic                valid_q, fstart_q, overrun_q;

   logic       xfer, x_last, y_last, frame_end, slot_free, issue, go_idle, wrap_to_gap, ovf;
   logic [7:0] x8, y8;

   always_comb begin
      xfer        = valid_q & out_ready_i;
      x_last      = (x_q == XLast);
      y_last      = (y_q == YLast);
      frame_end   = xfer & x_last & y_last;
      wrap_to_gap = frame_end & GapEn;
      slot_free   = ~valid_q | xfer;
      go_idle     = ~enable_i & slot_free;
      issue       = (state_q == StActive) & enable_i & slot_free & ~wrap_to_gap &
                    (tick_i | (pend_q != '0));

      // x_q/y_q track the presented pixel, and the next one to issue while nothing is valid
      x_d = x_q;
      y_d = y_q;
      if (xfer) begin
         x_d = x_last ? '0 : x_q + 1'b1;
         if (x_last) y_d = y_last ? '0 : y_q + 1'b1;
      end

      // With no gap the first pixel of the next frame may issue on the wrap cycle itself
      pat_d = frame_end ? pattern_sel_i : pat_q;
      x8    = 8'(x_d);
      y8    = 8'(y_d);
      case (pat_d)
         2'd0:    data_d = 8'hFF;
         2'd1:    data_d = 8'((32'(x_d) * 32'd256) / H_PIX);
         2'd2:    data_d = (x8[CB_BIT] ^ y8[CB_BIT]) ? 8'hFF : 8'h00;
         2'd3:    data_d = x8 ^ y8;
         default: data_d = 8'h00;
      endcase

      pend_d = pend_q;
      ovf    = 1'b0;
      if (tick_i && !issue) begin
         if (pend_q == PendMax) ovf = 1'b1;
         else                   pend_d = pend_q + 1'b1;
      end else if (!tick_i && issue) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= StIdle;
         x_q       <= '0;
         y_q       <= '0;
         pend_q    <= '0;
         gap_q     <= '0;
         pat_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         fstart_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         fstart_q <= 1'b0;
         if (go_idle) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            pend_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  state_q   <= StActive;
                  pat_q     <= pattern_sel_i;
                  overrun_q <= 1'b0;
               end
               StActive: begin
                  x_q    <= x_d;
                  y_q    <= y_d;
                  pat_q  <= pat_d;
                  pend_q <= pend_d;
                  if (ovf) overrun_q <= 1'b1;
                  if (issue) begin
                     valid_q  <= 1'b1;
                     data_q   <= data_d;
                     fstart_q <= (x_d == '0) && (y_d == '0);
                  end else if (xfer) begin
                     valid_q <= 1'b0;
                  end
                  if (wrap_to_gap) begin
                     state_q <= StGap;
                     pend_q  <= '0;
                  end
               end
               StGap: begin
                  if (tick_i) begin
                     if (gap_q == GapLast) begin
                        state_q <= StActive;
                        gap_q   <= '0;
                        pat_q   <= pattern_sel_i;
                     end else begin
                        gap_q <= gap_q + 1'b1;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign pix_valid_o   = valid_q;
   assign pix_x_o       = x_q;
   assign pix_y_o       = y_q;
   assign pix_data_o    = data_q;
   assign frame_start_o = fstart_q;
   assign frame_done_o  = frame_end;
   assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_tick_pixel_sequencer.sv
// Bench for tick_pixel_sequencer on a 4x2 raster: expected pixels are queued when ticks are
// driven and retired by a monitor as the DUT transfers them.
module tb_tick_pixel_sequencer;

   localparam int unsigned H  = 4;
   localparam int unsigned V  = 2;
   localparam int unsigned CB = 1;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic       tick = 1'b0;
   logic       enable = 1'b0;
   logic       out_ready = 1'b0;
   logic [1:0] pattern_sel = 2'd0;
   logic       pix_valid, frame_start, frame_done, overrun;
   logic [1:0] pix_x;
   logic [0:0] pix_y;
   logic [7:0] pix_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] x;
      logic [0:0] y;
      logic [7:0] d;
      logic       fs;
      logic       fd;
   } pix_t;

   pix_t       q[$];
   int         mx = 0;
   int         my = 0;
   logic [1:0] mpat = 2'd0;

   tick_pixel_sequencer #(
      .H_PIX    (4),
      .V_PIX    (2),
      .GAP_TICKS(1),
      .TICK_Q_W (2),
      .CB_BIT   (1)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .tick_i       (tick),
      .enable_i     (enable),
      .pattern_sel_i(pattern_sel),
      .out_ready_i  (out_ready),
      .pix_valid_o  (pix_valid),
      .pix_x_o      (pix_x),
      .pix_y_o      (pix_y),
      .pix_data_o   (pix_data),
      .frame_start_o(frame_start),
      .frame_done_o (frame_done),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_data(input logic [1:0] p, input int x, input int y);
      case (p)
         2'd0:    return 8'hFF;
         2'd1:    return 8'((x * 256) / int'(H));
         2'd2:    return ((((x >> CB) ^ (y >> CB)) & 1) != 0) ? 8'hFF : 8'h00;
         default: return 8'(x ^ y);
      endcase
   endfunction

   task automatic push_pixel(input bit use_d, input logic [7:0] d);
      pix_t p;
      if (mx == 0 && my == 0) mpat = pattern_sel;
      p.x  = 2'(mx);
      p.y  = 1'(my);
      p.d  = use_d ? d : model_data(mpat, mx, my);
      p.fs = (mx == 0 && my == 0);
      p.fd = (mx == int'(H) - 1 && my == int'(V) - 1);
      q.push_back(p);
      mx++;
      if (mx == int'(H)) begin
         mx = 0;
         my++;
         if (my == int'(V)) my = 0;
      end
   endtask

   task automatic pulse_tick();
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
   endtask

   task automatic emit_pixel();
      push_pixel(1'b0, 8'h00);
      pulse_tick();
      repeat (3) @(posedge clk);
   endtask

   // Scoreboard monitor
   logic       prev_valid = 1'b0, prev_xfer = 1'b0;
   logic [1:0] prev_x;
   logic [0:0] prev_y;
   logic [7:0] prev_d;

   always @(negedge clk) begin
      if (!nrst) begin
         prev_valid = 1'b0;
         prev_xfer  = 1'b0;
      end else begin
         checks++;
         if (pix_valid && (!prev_valid || prev_xfer)) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel: got (%0d,%0d) with no pixel expected", pix_x, pix_y);
            end else if (frame_start !== q[0].fs) begin
               errors++;
               $display("FAIL frame_start (%0d,%0d): got %b expected %b", pix_x, pix_y,
                        frame_start, q[0].fs);
            end
         end else if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_spurious: got %b expected 0", frame_start);
         end
         if (pix_valid && prev_valid && !prev_xfer) begin
            checks++;
            if (pix_x !== prev_x || pix_y !== prev_y || pix_data !== prev_d) begin
               errors++;
               $display("FAIL hold_stable: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)", pix_x, pix_y,
                        pix_data, prev_x, prev_y, prev_d);
            end
         end
         if (pix_valid && out_ready && q.size() > 0) begin
            pix_t e;
            e = q.pop_front();
            checks++;
            if (pix_x !== e.x || pix_y !== e.y || pix_data !== e.d || frame_done !== e.fd) begin
               errors++;
               $display("FAIL pixel: got (%0d,%0d) data %0h done %b expected (%0d,%0d) data %0h done %b",
                        pix_x, pix_y, pix_data, frame_done, e.x, e.y, e.d, e.fd);
            end
         end else begin
            checks++;
            if (frame_done !== 1'b0) begin
               errors++;
               $display("FAIL frame_done_spurious: got %b expected 0", frame_done);
            end
         end
         prev_valid = pix_valid;
         prev_xfer  = pix_valid & out_ready;
         prev_x     = pix_x;
         prev_y     = pix_y;
         prev_d     = pix_data;
      end
   end

   task automatic test_reset();
      #2 nrst = 1'b0;
      #2 checks++;
      if ({pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, overrun});
      end
      @(posedge clk); #1 nrst = 1'b1;
      pattern_sel = 2'd3;
      enable      = 1'b1;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      push_pixel(1'b0, 8'h00);
      pulse_tick();
      checks++;
      if (pix_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_valid: got %b expected 1", pix_valid);
      end
      pulse_tick();
      pulse_tick();
      @(posedge clk); #3 nrst = 1'b0;
      #1 checks++;
      if ({pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_async: got %b expected 0",
                  {pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, overrun});
      end
      q.delete();
      mx     = 0;
      my     = 0;
      enable = 1'b0;
      @(posedge clk); #1 nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         checks++;
         if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_tick: got %b expected 0", pix_valid);
         end
      end
   endtask

   task automatic test_frame();
      logic [7:0] tbl [8];
      tbl         = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd3, 8'd2};
      pattern_sel = 2'd3;
      out_ready   = 1'b1;
      enable      = 1'b1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         push_pixel(1'b1, tbl[i]);
         pulse_tick();
         checks++;
         if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_latency px%0d: got %b expected 1", i, pix_valid);
         end
         repeat (8) @(posedge clk);
      end
      pulse_tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_absorb: got %b expected 0", pix_valid);
         end
         @(posedge clk); #1;
      end
      push_pixel(1'b0, 8'h00);
      pulse_tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_x !== 2'd0 || pix_y !== 1'd0) begin
         errors++;
         $display("FAIL frame_restart: got valid %b (%0d,%0d) expected valid 1 (0,0)",
                  pix_valid, pix_x, pix_y);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_pixel(1'b0, 8'h00);
         pulse_tick();
         repeat (2) @(posedge clk);
      end
      #1 checks++;
      if (pix_valid !== 1'b1 || pix_x !== 2'd1 || pix_y !== 1'd0) begin
         errors++;
         $display("FAIL bp_hold: got valid %b (%0d,%0d) expected valid 1 (1,0)",
                  pix_valid, pix_x, pix_y);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_b2b cycle%0d: got %b expected 1", i, pix_valid);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got valid %b queued %0d expected valid 0 queued 0",
                  pix_valid, q.size());
      end
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      push_pixel(1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         pulse_tick();
         checks++;
         if (overrun !== (i == 4)) begin
            errors++;
            $display("FAIL overrun tick%0d: got %b expected %b", i + 1, overrun, (i == 4));
         end
         repeat (2) @(posedge clk);
      end
      push_pixel(1'b0, 8'h00);
      push_pixel(1'b0, 8'h00);
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 checks++;
      if (pix_valid !== 1'b0 || overrun !== 1'b1 || q.size() != 0) begin
         errors++;
         $display("FAIL overrun_drain: got valid %b overrun %b queued %0d expected 0 1 0",
                  pix_valid, overrun, q.size());
      end
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1 checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: got %b expected 1", overrun);
      end
      enable = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: got %b expected 0", overrun);
      end
   endtask

   task automatic test_enable_low();
      out_ready   = 1'b1;
      pattern_sel = 2'd3;
      emit_pixel();
      emit_pixel();
      #1 out_ready = 1'b0;
      push_pixel(1'b0, 8'h00);
      pulse_tick();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pix_valid !== 1'b1 || pix_x !== 2'd2 || pix_y !== 1'd0) begin
            errors++;
            $display("FAIL en_low_hold: got valid %b (%0d,%0d) expected valid 1 (2,0)",
                     pix_valid, pix_x, pix_y);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_low_release: got %b expected 0", pix_valid);
      end
      pulse_tick();
      checks++;
      if (pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_low_idle_tick: got %b expected 0", pix_valid);
      end
      mx     = 0;
      my     = 0;
      enable = 1'b1;
      repeat (2) @(posedge clk);
      push_pixel(1'b0, 8'h00);
      pulse_tick();
      checks++;
      if (pix_valid !== 1'b1 || frame_start !== 1'b1 || pix_x !== 2'd0 || pix_y !== 1'd0) begin
         errors++;
         $display("FAIL en_restart: got valid %b start %b (%0d,%0d) expected 1 1 (0,0)",
                  pix_valid, frame_start, pix_x, pix_y);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_pattern_switch();
      logic [1:0] next_sel [3];
      next_sel    = '{2'd1, 2'd0, 2'd3};
      pattern_sel = 2'd2;
      for (int i = 0; i < 7; i++) emit_pixel();
      for (int f = 0; f < 3; f++) begin
         pulse_tick();
         repeat (2) @(posedge clk);
         #1 checks++;
         if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL pat_gap frame%0d: got %b expected 0", f, pix_valid);
         end
         emit_pixel();
         pattern_sel = next_sel[f];
         for (int i = 0; i < 7; i++) emit_pixel();
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_overrun();
      test_enable_low();
      test_pattern_switch();
      for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pixels outstanding expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_pixel_sequencer.md
Name: tick_pixel_sequencer

Overview:
- Consumes the one-cycle tick pulse from the variable clock divider.
- Walks a raster of H_PIX x V_PIX coordinates and emits one grayscale test-pattern pixel per tick over a valid/ready stream to the display/frame-buffer writer.
- Queues ticks that arrive under backpressure, flags tick overrun, and inserts a programmable inter-frame gap counted in ticks.

Parameters:
- H_PIX, 16, pixels per line (>=2)
- V_PIX, 12, lines per frame (>=2)
- GAP_TICKS, 2, ticks idled between frames (0 = no gap)
- TICK_Q_W, 3, width of pending-tick counter; max queued ticks = 2^TICK_Q_W-1
- CB_BIT, 2, coordinate bit selecting checkerboard square size (2^CB_BIT)

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- tick  in  1  one-cycle advance pulse from clock divider
- enable  in  1  run request; low returns to IDLE
- pattern_sel  in  2  0 solid, 1 h-gradient, 2 checkerboard, 3 x^y
- out_ready  in  1  downstream accepts pixel
- pix_valid  out  1  pixel present
- pix_x  out  $clog2(H_PIX)  pixel column
- pix_y  out  $clog2(V_PIX)  pixel row
- pix_data  out  8  grayscale value
- frame_start  out  1  pulse: first pixel of frame becomes valid
- frame_done  out  1  pulse: last pixel of frame transferred
- overrun  out  1  sticky: tick lost (queue saturated)

Behaviour:
- Reset: nrst asynchronous, active-low; clock clk. All outputs 0, x=y=0, pend_cnt=0, gap_cnt=0, state IDLE, latched pattern=0.
- FSM states IDLE, ACTIVE, GAP.
  - IDLE->ACTIVE when enable=1. Latch pattern_sel; clear overrun.
  - ACTIVE->GAP on frame_done if GAP_TICKS>0; else stay ACTIVE (x=y=0, re-latch pattern_sel).
  - GAP->ACTIVE when gap_cnt reaches GAP_TICKS. Re-latch pattern_sel; gap_cnt=0.
  - Any state->IDLE when enable=0 and no pixel pending (pix_valid=0 or transferring this cycle). x, y, pend_cnt, gap_cnt cleared.
- Emission (ACTIVE only):
  - Condition: pix_valid=0 (or transferring this cycle) and (tick=1 or pend_cnt>0).
  - Next cycle: pix_valid=1 with x/y/data registered. Latency tick->pix_valid = 1 cycle.
- Handshake:
  - Transfer = pix_valid & out_ready.
  - pix_x/pix_y/pix_data held stable while pix_valid & !out_ready.
  - After a transfer, pix_valid drops unless another pixel issues the same cycle (back-to-back allowed from queue).
- Pending ticks:
  - tick not used for immediate issue in ACTIVE: pend_cnt+1.
  - Queued issue: pend_cnt-1.
  - Both in the same cycle: unchanged.
  - At 2^TICK_Q_W-1 with another unusable tick: saturate, set overrun=1.
  - Ticks in IDLE ignored. In GAP, ticks increment gap_cnt only. pend_cnt forced 0 on entering GAP.
- Raster: on transfer, x+1. At x=H_PIX-1: x=0, y+1. At (H_PIX-1, V_PIX-1): x=y=0 and frame_done=1 that cycle.
- frame_start=1 on the cycle pix_valid rises for (0,0).
- Patterns (8-bit; coords zero-extended or truncated to 8 bits):
  - 0: 0xFF
  - 1: x scaled as (x*256)/H_PIX, truncated
  - 2: 0xFF if x[CB_BIT]^y[CB_BIT], else 0x00
  - 3: x^y
- pattern_sel changes mid-frame are ignored until the next latch point.
- enable low mid-frame: a pending pixel is never dropped. It is held until transferred, then IDLE; no frame_done issued.

Test Plan:
- Reset: assert nrst=0 mid-run -> all outputs 0 immediately; after release with enable=0 -> pix_valid stays 0 despite ticks.
- H_PIX=4, V_PIX=2, GAP_TICKS=1, pattern 3, out_ready=1, tick every 10 cycles -> 8 pixels (0,0)..(3,1), data 0,1,2,3,1,0,3,2; pix_valid 1 cycle after each tick; frame_start with (0,0); frame_done with (3,1); one tick absorbed, next tick yields (0,0) with frame_start.
- Backpressure: out_ready=0 across 3 ticks -> first pixel held stable, pend_cnt=3; raise out_ready -> 3 further pixels back-to-back, one per cycle, then pend_cnt=0.
- Overrun: TICK_Q_W=2, out_ready=0 for 5 ticks -> pend_cnt=3, overrun=1 after the 5th tick; enable low->high clears overrun.
- enable=0 while pixel (2,0) valid and out_ready=0 -> (2,0) held until out_ready=1, then IDLE; re-enable -> restarts at (0,0) with frame_start.
- pattern_sel 3->2 mid-frame -> remaining pixels keep x^y; next frame uses checkerboard (CB_BIT=1: (2,0)=0xFF, (0,0)=0x00).
